// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the pipeline load/store port
//
// Accepts one word request at a time, waits a fixed access latency, then
// performs the load or store and returns a one-cycle acknowledge.
//
// Ports:
//   clk_i     in   1   clock, rising edge
//   rst_i     in   1   asynchronous active-high reset
//   req_i     in   1   request valid, sampled only while idle
//   we_i      in   1   1 = store, 0 = load (captured at acceptance)
//   addr_i    in  32   byte address (captured at acceptance)
//   wdata_i   in  32   store data (captured at acceptance)
//   ack_o     out  1   one-cycle completion pulse
//   rdata_o   out 32   load data, valid in ack cycle and held afterwards
//   err_o     out  1   misaligned / out-of-range request, valid with ack_o
//   busy_o    out  1   request outstanding, requester must stall

module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [31:0]       addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack_q,   ack_d;
  logic              err_q,   err_d;
  logic              busy_q,  busy_d;
  logic [31:0]       rdata_q, rdata_d;

  // Storage is deliberately outside the reset domain.
  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic              access_now;
  logic              mem_we;

  // Address decode always works on the captured copy, so the requester may
  // change its inputs freely while the access is in flight.
  assign idx          = addr_q[IDX_W+1:2];
  assign misaligned   = |addr_q[1:0];
  assign out_of_range = |addr_q[31:IDX_W+2];
  assign acc_err      = misaligned | out_of_range;

  assign access_now   = (state_q == ST_WAIT) && (cnt_q == '0);
  // rst_i gate covers the corner where reset rises on the access edge itself.
  assign mem_we       = access_now && we_q && !acc_err && !rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d   = 1'b1;
          err_d   = acc_err;
          if (!acc_err && !we_q) begin
            rdata_d = mem_q[idx];
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Ack cycle: whatever req_i shows here is ignored.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;

`ifndef SYNTHESIS
  ack_single_cycle: assert property (@(posedge clk_i) disable iff (rst_i) ack_o |=> !ack_o);
  ack_implies_busy: assert property (@(posedge clk_i) disable iff (rst_i) ack_o |-> busy_o);
  err_implies_ack:  assert property (@(posedge clk_i) disable iff (rst_i) err_o |-> ack_o);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT0 = 10;
  localparam int LAT1 = 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        ack_o, err_o, busy_o;
  logic [31:0] rdata_o;

  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        ack1, err1, busy1;
  logic [31:0] rdata1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT0)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req1), .we_i(we1),
    .addr_i(addr1), .wdata_i(wdata1), .ack_o(ack1),
    .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitors: pop an expectation on every ack and compare.
  always @(negedge clk) begin
    if (ack_o === 1'b1) begin
      chk("m0_busy_with_ack", {31'd0, busy_o}, 32'd1);
      if (q0.size() == 0) begin
        chk("m0_unexpected_ack", {31'd0, ack_o}, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("m0_err", {31'd0, err_o}, {31'd0, e0.err});
        chk("m0_rdata", rdata_o, e0.rd);
        chk("m0_ack_cycle", 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("m1_unexpected_ack", {31'd0, ack1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("m1_err", {31'd0, err1}, {31'd0, e1.err});
        chk("m1_rdata", rdata1, e1.rd);
        chk("m1_ack_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic e, input logic [31:0] rd, input bit disturb);
    int ec;
    int g;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    ec = cyc + 1 + LAT0;
    q0.push_back('{e, rd, ec});
    @(negedge clk);
    req_i = 1'b0;
    chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
    if (disturb) begin
      addr_i = 32'h24; we_i = ~we; wdata_i = 32'h0000_0BAD; req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0; we_i = we;
      @(negedge clk);
    end
    g = 0;
    while (cyc < ec + 1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("busy_low_after_done", {31'd0, busy_o}, 32'd0);
    chk("ack_low_after_done", {31'd0, ack_o}, 32'd0);
    chk("err_low_after_done", {31'd0, err_o}, 32'd0);
  endtask

  logic        t_we  [6];
  logic [31:0] t_a   [6];
  logic [31:0] t_wd  [6];
  logic        t_err [6];
  logic [31:0] t_rd  [6];

  initial begin
    int g;
    req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    rst_i = 1'b1;
    #1;
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    issue(1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        0);
    issue(0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 0);
    issue(0, 32'h13,       32'h0,        1, 32'hDEADBEEF, 0);
    issue(1, 32'h0,        32'h11111111, 0, 32'hDEADBEEF, 0);
    issue(1, 32'h1000,     32'h99999999, 1, 32'hDEADBEEF, 0);
    issue(0, 32'h0,        32'h0,        0, 32'h11111111, 0);
    issue(1, 32'h20,       32'h5,        0, 32'h11111111, 0);
    issue(1, 32'h24,       32'hA,        0, 32'h11111111, 0);
    issue(0, 32'h20,       32'h0,        0, 32'h5,        1);
    issue(0, 32'h24,       32'h0,        0, 32'hA,        0);
    issue(1, 32'h30,       32'h7,        0, 32'hA,        0);

    // Store aborted by a mid-cycle reset during WAIT.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; wdata_i = 32'h77;
    @(negedge clk);
    req_i = 1'b0;
    chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort_ack", {31'd0, ack_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_err", {31'd0, err_o}, 32'd0);
    chk("abort_rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (LAT0 + 5) @(negedge clk);
    chk("abort_idle", {31'd0, busy_o}, 32'd0);

    issue(0, 32'h30,       32'h0,        0, 32'h7,        0);
    issue(0, 32'h80000000, 32'h0,        1, 32'h7,        0);

    // Back-to-back on the LATENCY=1 instance: req dropped only in ack cycles.
    t_we[0] = 1; t_a[0] = 32'h04; t_wd[0] = 32'hA5A5A5A5; t_err[0] = 0; t_rd[0] = 32'h0;
    t_we[1] = 0; t_a[1] = 32'h04; t_wd[1] = 32'h0;        t_err[1] = 0; t_rd[1] = 32'hA5A5A5A5;
    t_we[2] = 0; t_a[2] = 32'h06; t_wd[2] = 32'h0;        t_err[2] = 1; t_rd[2] = 32'hA5A5A5A5;
    t_we[3] = 1; t_a[3] = 32'h40; t_wd[3] = 32'hFFFFFFFF; t_err[3] = 1; t_rd[3] = 32'hA5A5A5A5;
    t_we[4] = 1; t_a[4] = 32'h3C; t_wd[4] = 32'h12345678; t_err[4] = 0; t_rd[4] = 32'hA5A5A5A5;
    t_we[5] = 0; t_a[5] = 32'h3C; t_wd[5] = 32'h0;        t_err[5] = 0; t_rd[5] = 32'h12345678;
    @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      req1 = 1'b1; we1 = t_we[n]; addr1 = t_a[n]; wdata1 = t_wd[n];
      q1.push_back('{t_err[n], t_rd[n], cyc + 2});
      @(negedge clk);
      g = 0;
      while (ack1 !== 1'b1 && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk("b2b_ack_seen", {31'd0, ack1}, 32'd1);
      req1 = 1'b0;
      @(negedge clk);
      chk("b2b_ack_one_cycle", {31'd0, ack1}, 32'd0);
    end
    repeat (3) @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
